// File: rtl/ee201_numlock_defs.sv
// Shared definitions for the number-lock button front-end:
// one-hot channel state codes and the debounce lengths used on the board and in simulation.
package ee201_numlock_defs;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_INI     = 4'b0001;
    localparam logic [STATE_W-1:0] ST_WQ_P    = 4'b0010;
    localparam logic [STATE_W-1:0] ST_PRESSED = 4'b0100;
    localparam logic [STATE_W-1:0] ST_WQ_R    = 4'b1000;

    localparam int DB_CYCLES_SIM   = 4;
    localparam int DB_CYCLES_BOARD = 1048576;

    // The debounced level is high while pressed or while a release is still being qualified.
    function automatic logic dpb_of(input logic [STATE_W-1:0] st);
        return (st == ST_PRESSED) || (st == ST_WQ_R);
    endfunction

endpackage

// File: rtl/ee201_debounce_chan.sv
// One button channel: two-flop synchronizer, quiet-time counter and a four-state
// one-hot FSM producing a registered debounced level and a one-clock press pulse.
module ee201_debounce_chan
    import ee201_numlock_defs::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_SIM
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic raw,
    output logic DPB,
    output logic SCEN
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               dpb_q;
    logic               dpb_d;
    logic               scen_q;
    logic               scen_d;

    // Two-flop synchronizer, nothing between the stages
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INI;
            cnt_q   <= CNT_ZERO;
            dpb_q   <= 1'b0;
            scen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dpb_q   <= dpb_d;
            scen_q  <= scen_d;
        end
    end

    // Next-state logic; the counter restarts on every entry to a wait-quiet state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INI: begin
                if (sync2_q) begin
                    state_d = ST_WQ_P;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_INI;
                end
            end
            ST_WQ_P: begin
                if (!sync2_q) begin
                    state_d = ST_INI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d = ST_WQ_R;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_WQ_R: begin
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_INI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_INI;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state so both outputs land with the state change
    always_comb begin
        dpb_d  = dpb_of(state_d);
        scen_d = (state_q == ST_WQ_P) && (state_d == ST_PRESSED);
    end

    assign DPB  = dpb_q;
    assign SCEN = scen_q;

endmodule

// File: rtl/ee201_numlock_debouncer.sv
// Front-end for the number-lock FSM: two independent debounce channels for the
// U and Z buttons, each giving a clean level and a single-clock press pulse.
module ee201_numlock_debouncer
    import ee201_numlock_defs::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_SIM
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic BtnU_raw,
    input  logic BtnZ_raw,
    output logic U,
    output logic Z,
    output logic U_scen,
    output logic Z_scen
);

    ee201_debounce_chan #(
        .DB_CYCLES (DB_CYCLES)
    ) u_chan_u (
        .Clk     (Clk),
        .reset_n (reset_n),
        .raw     (BtnU_raw),
        .DPB     (U),
        .SCEN    (U_scen)
    );

    ee201_debounce_chan #(
        .DB_CYCLES (DB_CYCLES)
    ) u_chan_z (
        .Clk     (Clk),
        .reset_n (reset_n),
        .raw     (BtnZ_raw),
        .DPB     (Z),
        .SCEN    (Z_scen)
    );

endmodule

// File: tb/tb_ee201_numlock_debouncer.sv
// Scoreboard bench for the number-lock debouncer: each scenario queues the expected
// {U,Z,U_scen,Z_scen} for every upcoming cycle, a negedge monitor pops and compares.
module tb_ee201_numlock_debouncer;

    localparam int NONE = 1 << 30;

    typedef struct {
        int         cyc;
        logic [3:0] val;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_u = 1'b0;
    logic btn_z = 1'b0;
    logic u;
    logic z;
    logic u_scen;
    logic z_scen;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    ee201_numlock_debouncer #(
        .DB_CYCLES (4)
    ) dut (
        .Clk      (clk),
        .reset_n  (rst_n),
        .BtnU_raw (btn_u),
        .BtnZ_raw (btn_z),
        .U        (u),
        .Z        (z),
        .U_scen   (u_scen),
        .Z_scen   (z_scen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    // Pop and compare every expectation due in the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check_eq($sformatf("%s@%0d", e.tag, cyc), 32'({u, z, u_scen, z_scen}), 32'(e.val));
        end
    end

    // Expected outputs for cycles [from,to]: a level is high in [rise,fall), its pulse only at rise
    task automatic push_span(input int from, input int to, input int ur, input int uf,
                             input int zr, input int zf, input string tag);
        for (int c = from; c <= to; c++) begin
            exp_t e;
            e.cyc = c;
            e.val = {(c >= ur && c < uf), (c >= zr && c < zf), (c == ur), (c == zr)};
            e.tag = tag;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start(output int p);
        @(posedge clk);
        #1;
        p = cyc;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int p;

        // Reset with both buttons held, then release reset
        rst_n = 1'b0;
        btn_u = 1'b1;
        btn_z = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outs", 32'({u, z, u_scen, z_scen}), 32'd0);
        p = cyc;
        rst_n = 1'b1;
        push_span(p + 1, p + 22, p + 7, p + 19, p + 7, p + 19, "rst_rel");
        wait_to(p + 12);
        btn_u = 1'b0;
        btn_z = 1'b0;
        drain("rst_rel");

        // Clean U press held 20 clocks, then release
        start(p);
        btn_u = 1'b1;
        push_span(p + 1, p + 30, p + 7, p + 27, NONE, NONE, "clean");
        wait_to(p + 20);
        btn_u = 1'b0;
        drain("clean");

        // Bouncing Z press 1,0,1,0,1 then held
        start(p);
        btn_z = 1'b1;
        push_span(p + 1, p + 30, NONE, NONE, p + 11, p + 27, "bounce");
        wait_to(p + 1); btn_z = 1'b0;
        wait_to(p + 2); btn_z = 1'b1;
        wait_to(p + 3); btn_z = 1'b0;
        wait_to(p + 4); btn_z = 1'b1;
        wait_to(p + 20);
        btn_z = 1'b0;
        drain("bounce");

        // Three-clock U glitch is rejected
        start(p);
        btn_u = 1'b1;
        push_span(p + 1, p + 12, NONE, NONE, NONE, NONE, "glitch");
        wait_to(p + 3);
        btn_u = 1'b0;
        drain("glitch");

        // Two-clock low dropout while pressed keeps U high
        start(p);
        btn_u = 1'b1;
        push_span(p + 1, p + 30, p + 7, p + 27, NONE, NONE, "dropout");
        wait_to(p + 10); btn_u = 1'b0;
        wait_to(p + 12); btn_u = 1'b1;
        wait_to(p + 20); btn_u = 1'b0;
        drain("dropout");

        // Simultaneous presses debounce together
        start(p);
        btn_u = 1'b1;
        btn_z = 1'b1;
        push_span(p + 1, p + 20, p + 7, p + 17, p + 7, p + 17, "simul");
        wait_to(p + 10);
        btn_u = 1'b0;
        btn_z = 1'b0;
        drain("simul");

        // Reset while qualifying a press (WQ_P, cnt=2), then re-debounce the held button
        start(p);
        btn_u = 1'b1;
        push_span(p + 1, p + 5, NONE, NONE, NONE, NONE, "pre_rst");
        wait_to(p + 5);
        rst_n = 1'b0;
        #1;
        check_eq("midop_rst", 32'({u, z, u_scen, z_scen}), 32'd0);
        drain("pre_rst");
        repeat (2) @(posedge clk);
        #1;
        p = cyc;
        rst_n = 1'b1;
        push_span(p + 1, p + 12, p + 7, NONE, NONE, NONE, "re_db");
        drain("re_db");

        // Asynchronous reset while pressed clears outputs at once
        rst_n = 1'b0;
        #1;
        check_eq("pressed_rst", 32'({u, z, u_scen, z_scen}), 32'd0);
        @(posedge clk);
        #1;
        check_eq("held_rst", 32'({u, z, u_scen, z_scen}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ee201_numlock_debouncer.md
Name: ee201_numlock_debouncer

Overview:
- Upstream front-end for the number-lock state machine.
- Takes the two raw, asynchronous, bouncing push-button inputs and delivers clean, synchronous, debounced levels U and Z. The lock FSM consumes these directly, including its "wait for release" states.
- Also provides a one-clock press pulse per button, for the display/LED logic.
- Two identical channels, one per button.

Parameters:
- DB_CYCLES, 4, stable-sample count required to accept a press or release. Minimum 2; use 2**20 (~10 ms at 100 MHz) on the board and 4 in simulation.
- CNT_W, $clog2(DB_CYCLES+1), width of the debounce counter. Derived; not overridden.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- BtnU_raw  in  1  raw "U" (one) button, asynchronous, bouncing, active-high.
- BtnZ_raw  in  1  raw "Z" (zero) button, asynchronous, bouncing, active-high.
- U  out  1  debounced level of BtnU, registered.
- Z  out  1  debounced level of BtnZ, registered.
- U_scen  out  1  single-clock pulse on an accepted U press.
- Z_scen  out  1  single-clock pulse on an accepted Z press.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Synchronizer flops = 0, counters = 0, FSM = INI.
  - U = Z = U_scen = Z_scen = 0.
- Synchronizer: 2-flop chain per input. sync_x reflects raw_x 2 clocks later. No logic between the flops.
- Per-channel FSM, one-hot, 4 states; DPB is the channel's level output (U or Z):
  - INI (DPB=0): sync=1 -> WQ_P with cnt<=0. Otherwise stay.
  - WQ_P, wait-quiet press (DPB=0):
    - sync=0 -> INI.
    - sync=1 and cnt==DB_CYCLES-1 -> PRESSED.
    - Otherwise cnt<=cnt+1.
  - PRESSED (DPB=1): sync=0 -> WQ_R with cnt<=0. Otherwise stay.
  - WQ_R, wait-quiet release (DPB=1):
    - sync=1 -> PRESSED.
    - sync=0 and cnt==DB_CYCLES-1 -> INI.
    - Otherwise cnt<=cnt+1.
- DPB is registered and equals 1 exactly when the state is PRESSED or WQ_R.
- SCEN is registered and high for exactly the one cycle after the WQ_P->PRESSED transition. It is never high for two consecutive cycles.
- Latency: raw rises before edge 0 and stays stable -> DPB high after edge DB_CYCLES+2. Release latency is identical.
- Glitch rejection: a raw pulse (or a bounce gap) whose synchronized width is < DB_CYCLES clocks produces no DPB change and no SCEN.
- Counter never wraps: it is reset on every entry to WQ_P/WQ_R and bounded by DB_CYCLES-1.
- Channels are fully independent:
  - Simultaneous presses debounce concurrently.
  - U and Z may both be 1; the downstream lock FSM treats UZ=11 as "no valid digit".
- Reset mid-debounce:
  - Everything returns to INI immediately.
  - A button still held after reset_n deasserts is re-debounced as a fresh press: full latency, and SCEN fires.
- No combinational path from any input to any output.

Decomposition:
- Shared package/include ee201_numlock_defs: the channel state codes (INI, WQ_P, PRESSED, WQ_R as 4-bit one-hot localparams) and the default DB_CYCLES values for simulation and board.
- One sub-module, ee201_debounce_chan: synchronizer, counter and FSM for a single button, with ports Clk, reset_n, raw, DPB, SCEN and parameter DB_CYCLES.
- Top level instantiates it twice and renames the outputs.

Test Plan:
- Reset: reset_n=0 while BtnU_raw=BtnZ_raw=1 -> U=Z=U_scen=Z_scen=0. Release reset -> U rises after edge 6 (DB_CYCLES=4), U_scen high exactly 1 cycle.
- Clean press: BtnU_raw 0->1 held 20 clocks -> U=1 after edge 6, one U_scen pulse. Release -> U=0 after edge 6 of release, no extra pulse.
- Bounce: BtnZ_raw toggles 1,0,1,0,1 (1 clock each) then holds 1 -> exactly one Z_scen. Z rises 6 clocks after the final stable edge.
- Glitch: BtnU_raw high for 3 clocks then low -> U stays 0, U_scen never asserted. A 2-clock low dropout while PRESSED -> U stays 1.
- Simultaneous: both raw inputs rise on the same edge -> U and Z rise on the same cycle, U_scen and Z_scen on the same cycle.
- Reset mid-op: assert reset_n=0 while in WQ_P with cnt=2 -> outputs 0 immediately. Deassert with the button held -> full 6-clock latency, one U_scen.
